// File: rtl/sa_pkg.sv
// Shared constants, FSM state type and operand address helpers for the SA skew feeder.
package sa_pkg;
  localparam int N        = 4;
  localparam int FEED_CYC = 2 * N - 1;
  localparam int A_BASE   = 0;
  localparam int B_BASE   = 16;

  typedef enum logic [2:0] {IDLE, CLEAR, FEED, DRAIN, DONE} state_t;

  // A[r][k] lives at A_BASE + 4r + k
  function automatic logic [4:0] a_addr(input logic [1:0] r, input logic [1:0] k);
    return 5'(A_BASE) + {1'b0, r, k};
  endfunction

  // B[k][j] lives at B_BASE + 4j + k
  function automatic logic [4:0] b_addr(input logic [1:0] k, input logic [1:0] j);
    return 5'(B_BASE) + {1'b0, j, k};
  endfunction
endpackage

// File: rtl/sa_operand_bank.sv
// 32-word operand register file: one write port, every word readable combinationally.
module sa_operand_bank #(
  parameter int DW = 10
) (
  input  logic          clk,
  input  logic          we,
  input  logic [4:0]    addr,
  input  logic [DW-1:0] data,
  output logic [DW-1:0] words [32]
);
  // No reset: stored operands survive a reset of the feeder.
  logic [DW-1:0] mem [32];

  always_ff @(posedge clk) begin
    if (we) mem[addr] <= data;
  end

  assign words = mem;
endmodule

// File: rtl/sa_skew_feeder.sv
// Streams diagonally skewed A/B operands into a 4x4 systolic array and flags when its results are valid.
module sa_skew_feeder
  import sa_pkg::*;
#(
  parameter int DW        = 10,
  parameter int DRAIN_CYC = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          wr_en,
  input  logic [4:0]    wr_addr,
  input  logic [DW-1:0] wr_data,
  input  logic          start,
  output logic          busy,
  output logic          done,
  output logic          sa_clear,
  output logic [DW-1:0] a1,
  output logic [DW-1:0] a2,
  output logic [DW-1:0] a3,
  output logic [DW-1:0] a4,
  output logic [DW-1:0] b1,
  output logic [DW-1:0] b2,
  output logic [DW-1:0] b3,
  output logic [DW-1:0] b4
);
  localparam logic [2:0] LAST_FEED  = 3'(FEED_CYC - 1);
  localparam logic [2:0] LAST_DRAIN = 3'(DRAIN_CYC - 1);

  state_t        state;
  logic [2:0]    step;
  logic [DW-1:0] words [32];
  logic          load;
  logic [2:0]    feed_t;
  logic [DW-1:0] lane_a [N];
  logic [DW-1:0] lane_b [N];

  sa_operand_bank #(.DW(DW)) u_bank (
    .clk   (clk),
    .we    (wr_en && state == IDLE),
    .addr  (wr_addr),
    .data  (wr_data),
    .words (words)
  );

  // Lanes are computed for the step about to become visible, so the registered
  // outputs line up with the state they are listed under.
  assign load   = (state == CLEAR) || (state == FEED && step != LAST_FEED);
  assign feed_t = (state == FEED) ? step + 3'd1 : 3'd0;

  always_comb begin
    for (int unsigned i = 0; i < N; i++) begin
      lane_a[i] = '0;
      lane_b[i] = '0;
      if (load && feed_t >= 3'(i) && (feed_t - 3'(i)) < 3'(N)) begin
        lane_a[i] = words[a_addr(2'(i), 2'(feed_t - 3'(i)))];
        lane_b[i] = words[b_addr(2'(feed_t - 3'(i)), 2'(i))];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      step     <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      sa_clear <= 1'b0;
      a1 <= '0; a2 <= '0; a3 <= '0; a4 <= '0;
      b1 <= '0; b2 <= '0; b3 <= '0; b4 <= '0;
    end else begin
      sa_clear <= 1'b0;
      done     <= 1'b0;
      a1 <= lane_a[0]; a2 <= lane_a[1]; a3 <= lane_a[2]; a4 <= lane_a[3];
      b1 <= lane_b[0]; b2 <= lane_b[1]; b3 <= lane_b[2]; b4 <= lane_b[3];
      case (state)
        IDLE: begin
          if (start) begin
            state    <= CLEAR;
            sa_clear <= 1'b1;
            busy     <= 1'b1;
          end
        end
        CLEAR: begin
          state <= FEED;
          step  <= '0;
        end
        FEED: begin
          if (step == LAST_FEED) begin
            state <= DRAIN;
            step  <= '0;
          end else begin
            step <= step + 3'd1;
          end
        end
        DRAIN: begin
          if (step == LAST_DRAIN) begin
            state <= DONE;
            done  <= 1'b1;
          end else begin
            step <= step + 3'd1;
          end
        end
        DONE: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_sa_skew_feeder.sv
// Directed bench for sa_skew_feeder: per-cycle expectations are queued at start and compared as the run unfolds.
module tb_sa_skew_feeder;
  localparam int DW = 10;

  typedef struct packed {
    logic               busy;
    logic               done;
    logic               clr;
    logic [3:0][DW-1:0] a;
    logic [3:0][DW-1:0] b;
  } exp_t;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          wr_en = 1'b0;
  logic [4:0]    wr_addr = '0;
  logic [DW-1:0] wr_data = '0;
  logic          start = 1'b0;
  logic          busy, done, sa_clear;
  logic [DW-1:0] a1, a2, a3, a4, b1, b2, b3, b4;

  logic [DW-1:0] mem [32];
  exp_t          sb [$];
  int            total = 0;
  int            bad = 0;

  always #5 clk = ~clk;

  sa_skew_feeder #(.DW(DW), .DRAIN_CYC(4)) dut (
    .clk(clk), .reset(reset), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .start(start), .busy(busy), .done(done), .sa_clear(sa_clear),
    .a1(a1), .a2(a2), .a3(a3), .a4(a4), .b1(b1), .b2(b2), .b3(b3), .b4(b4)
  );

  function automatic exp_t idle_exp();
    exp_t e;
    e = '0;
    return e;
  endfunction

  // Lane i (0-based) carries A[i][t-i] / B[t-i][i] when 0 <= t-i <= 3.
  function automatic exp_t feed_exp(input int t);
    exp_t e;
    e = '0;
    e.busy = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (t - i >= 0 && t - i <= 3) begin
        e.a[i] = mem[4 * i + (t - i)];
        e.b[i] = mem[16 + 4 * i + (t - i)];
      end
    end
    return e;
  endfunction

  task automatic push_run();
    exp_t e;
    e = idle_exp(); e.busy = 1'b1; e.clr = 1'b1;
    sb.push_back(e);
    for (int t = 0; t < 7; t++) sb.push_back(feed_exp(t));
    e = idle_exp(); e.busy = 1'b1;
    for (int d = 0; d < 4; d++) sb.push_back(e);
    e.done = 1'b1;
    sb.push_back(e);
    sb.push_back(idle_exp());
  endtask

  task automatic check(input exp_t e);
    exp_t o;
    o.busy = busy; o.done = done; o.clr = sa_clear;
    o.a = {a4, a3, a2, a1};
    o.b = {b4, b3, b2, b1};
    total++;
    assert (o.busy === e.busy) else begin bad++; $error("FAIL busy observed=%b expected=%b", o.busy, e.busy); end
    total++;
    assert (o.done === e.done) else begin bad++; $error("FAIL done observed=%b expected=%b", o.done, e.done); end
    total++;
    assert (o.clr === e.clr) else begin bad++; $error("FAIL sa_clear observed=%b expected=%b", o.clr, e.clr); end
    total++;
    assert (o.a === e.a) else begin bad++; $error("FAIL a_lanes observed=%h expected=%h", o.a, e.a); end
    total++;
    assert (o.b === e.b) else begin bad++; $error("FAIL b_lanes observed=%h expected=%h", o.b, e.b); end
  endtask

  task automatic tick();
    exp_t e;
    @(posedge clk);
    #1;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      check(e);
    end
  endtask

  task automatic wr(input int addr, input int data, input bit track);
    wr_en = 1'b1; wr_addr = 5'(addr); wr_data = DW'(data);
    if (track) mem[addr] = DW'(data);
    tick();
    wr_en = 1'b0;
  endtask

  task automatic drain();
    int guard;
    guard = 0;
    while (sb.size() > 0 && guard < 100) begin
      tick();
      guard++;
    end
    total++;
    assert (sb.size() == 0) else begin bad++; $error("FAIL drain_timeout observed=%0d expected=0", sb.size()); end
  endtask

  initial begin
    for (int i = 0; i < 32; i++) mem[i] = '0;

    // reset state
    tick(); tick();
    sb.push_back(idle_exp());
    tick();
    reset = 1'b0;

    // load word[i] = i, one full run
    for (int i = 0; i < 32; i++) wr(i, i, 1'b1);
    push_run();
    start = 1'b1;
    tick();
    start = 1'b0;
    drain();

    // start during FEED t=2 and a write during DRAIN are both ignored
    push_run();
    sb.push_back(idle_exp());
    sb.push_back(idle_exp());
    for (int c = 0; c < 16; c++) begin
      start   = (c == 0 || c == 4);
      wr_en   = (c == 9);
      wr_addr = 5'd0;
      wr_data = 10'd1023;
      tick();
    end
    start = 1'b0; wr_en = 1'b0;
    drain();

    // reset at FEED t=2, then an identical replay
    push_run();
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (3) tick();
    reset = 1'b1;
    sb.delete();
    sb.push_back(idle_exp());
    tick();
    reset = 1'b0;
    sb.push_back(idle_exp());
    tick();
    push_run();
    start = 1'b1;
    tick();
    start = 1'b0;
    drain();

    // all words full-scale; last write shares its cycle with start
    for (int i = 0; i < 31; i++) wr(i, 1023, 1'b1);
    wr_en = 1'b1; wr_addr = 5'd31; wr_data = 10'd1023; mem[31] = 10'd1023;
    start = 1'b1;
    push_run();
    tick();
    wr_en = 1'b0; start = 1'b0;
    drain();

    // start held through DONE: second run only after one IDLE cycle
    for (int i = 0; i < 32; i++) wr(i, (i * 37 + 5) % 1024, 1'b1);
    push_run();
    push_run();
    start = 1'b1;
    repeat (16) tick();
    start = 1'b0;
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule
